// File: rtl/ay_psg_pkg.sv
// Shared constants for the AY-style tone/noise core: register map, widths and
// the noise LFSR seed/taps.
package ay_psg_pkg;

    localparam int TONE_W  = 12;
    localparam int NOISE_W = 5;
    localparam int LFSR_W  = 17;

    localparam logic [3:0] AY_R_AFINE   = 4'd0;
    localparam logic [3:0] AY_R_ACOARSE = 4'd1;
    localparam logic [3:0] AY_R_BFINE   = 4'd2;
    localparam logic [3:0] AY_R_BCOARSE = 4'd3;
    localparam logic [3:0] AY_R_CFINE   = 4'd4;
    localparam logic [3:0] AY_R_CCOARSE = 4'd5;
    localparam logic [3:0] AY_R_NOISE   = 4'd6;
    localparam logic [3:0] AY_R_MIXER   = 4'd7;
    localparam logic [3:0] AY_R_VOLA    = 4'd8;
    localparam logic [3:0] AY_R_VOLB    = 4'd9;
    localparam logic [3:0] AY_R_VOLC    = 4'd10;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 17'h00001;
    localparam int LFSR_TAP0 = 0;
    localparam int LFSR_TAP1 = 3;

    // Right shift, feedback enters at the top; maximal length so never all-zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_TAP0] ^ s[LFSR_TAP1], s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/ay_psg_tone_noise_if.sv
// CPU register-file port of the tone/noise core.
interface ay_psg_tone_noise_if;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output wr, addr, din, input dout);
    modport slave  (input wr, addr, din, output dout);
endinterface

// File: rtl/ay_period_counter.sv
// Clock-enabled period counter; pulses o_wrap on the enable where cnt+1 >= period.
module ay_period_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_ce,
    input  logic [W-1:0] i_period,
    output logic         o_wrap
);
    logic [W-1:0] r_cnt;
    logic [W:0]   w_next;

    // One extra bit so cnt+1 never overflows; >= makes period 0 act as 1 and
    // makes a lowered period wrap at once instead of running through the top.
    assign w_next = {1'b0, r_cnt} + {{W{1'b0}}, 1'b1};
    assign o_wrap = i_ce && (w_next >= {1'b0, i_period});

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_ce) begin
            r_cnt <= o_wrap ? '0 : w_next[W-1:0];
        end
    end
endmodule

// File: rtl/ay_psg_tone_noise.sv
// AY-3-8910-style core: register file, three tone channels, LFSR noise, mixer
// and registered 4-bit amplitude outputs.
module ay_psg_tone_noise
    import ay_psg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    ay_psg_tone_noise_if.slave bus,
    output logic [3:0]         ch_a,
    output logic [3:0]         ch_b,
    output logic [3:0]         ch_c
);
    logic [7:0]         r_fine   [3];
    logic [3:0]         r_coarse [3];
    logic [3:0]         r_vol    [3];
    logic [NOISE_W-1:0] r_noise_per;
    logic [5:0]         r_mixer;
    logic [2:0]         r_tone;
    logic               r_prescale;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [3:0]         r_ch     [3];
    logic [2:0]         w_tone_wrap;
    logic               w_noise_wrap;
    logic [2:0]         w_on;

    // NOTE: the register file is ordinary flops, so it is reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                r_fine[i]   <= '0;
                r_coarse[i] <= '0;
                r_vol[i]    <= '0;
            end
            r_noise_per <= '0;
            r_mixer     <= '0;
        end else if (bus.wr) begin
            case (bus.addr)
                AY_R_AFINE:   r_fine[0]   <= bus.din;
                AY_R_ACOARSE: r_coarse[0] <= bus.din[3:0];
                AY_R_BFINE:   r_fine[1]   <= bus.din;
                AY_R_BCOARSE: r_coarse[1] <= bus.din[3:0];
                AY_R_CFINE:   r_fine[2]   <= bus.din;
                AY_R_CCOARSE: r_coarse[2] <= bus.din[3:0];
                AY_R_NOISE:   r_noise_per <= bus.din[NOISE_W-1:0];
                AY_R_MIXER:   r_mixer     <= bus.din[5:0];
                AY_R_VOLA:    r_vol[0]    <= bus.din[3:0];
                AY_R_VOLB:    r_vol[1]    <= bus.din[3:0];
                AY_R_VOLC:    r_vol[2]    <= bus.din[3:0];
                default:      ;
            endcase
        end
    end

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        bus.dout = 8'h00;
        case (bus.addr)
            AY_R_AFINE:   bus.dout = r_fine[0];
            AY_R_ACOARSE: bus.dout = {4'h0, r_coarse[0]};
            AY_R_BFINE:   bus.dout = r_fine[1];
            AY_R_BCOARSE: bus.dout = {4'h0, r_coarse[1]};
            AY_R_CFINE:   bus.dout = r_fine[2];
            AY_R_CCOARSE: bus.dout = {4'h0, r_coarse[2]};
            AY_R_NOISE:   bus.dout = {3'h0, r_noise_per};
            AY_R_MIXER:   bus.dout = {2'h0, r_mixer};
            AY_R_VOLA:    bus.dout = {4'h0, r_vol[0]};
            AY_R_VOLB:    bus.dout = {4'h0, r_vol[1]};
            AY_R_VOLC:    bus.dout = {4'h0, r_vol[2]};
            default:      ;
        endcase
    end

    for (genvar i = 0; i < 3; i++) begin : g_tone
        ay_period_counter #(.W(TONE_W)) u_tone (
            .clk      (clk),
            .reset    (reset),
            .i_ce     (ce),
            .i_period ({r_coarse[i], r_fine[i]}),
            .o_wrap   (w_tone_wrap[i])
        );
    end

    // Noise runs at half the tone rate: it only sees enables where the prescaler is 1.
    ay_period_counter #(.W(NOISE_W)) u_noise (
        .clk      (clk),
        .reset    (reset),
        .i_ce     (ce & r_prescale),
        .i_period (r_noise_per),
        .o_wrap   (w_noise_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tone     <= '0;
            r_prescale <= 1'b0;
            r_lfsr     <= LFSR_SEED;
        end else begin
            r_tone <= r_tone ^ w_tone_wrap;
            if (ce) begin
                r_prescale <= ~r_prescale;
            end
            if (w_noise_wrap) begin
                r_lfsr <= lfsr_next(r_lfsr);
            end
        end
    end

    // Mixer enables are active-low: a set bit forces that source's term to 1.
    always_comb begin
        w_on = '0;
        for (int i = 0; i < 3; i++) begin
            w_on[i] = (r_tone[i] | r_mixer[i]) & (r_lfsr[0] | r_mixer[i+3]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) r_ch[i] <= 4'h0;
        end else begin
            for (int i = 0; i < 3; i++) r_ch[i] <= w_on[i] ? r_vol[i] : 4'h0;
        end
    end

    assign ch_a = r_ch[0];
    assign ch_b = r_ch[1];
    assign ch_c = r_ch[2];
endmodule

// File: tb/tb_ay_psg_tone_noise.sv
// Bench for ay_psg_tone_noise: cycle model compared every clk plus hand-derived
// waveform intervals, readbacks and reset values.
module tb_ay_psg_tone_noise;
    import ay_psg_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic [3:0] ch_a, ch_b, ch_c;

    ay_psg_tone_noise_if bus ();

    ay_psg_tone_noise dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus),
        .ch_a  (ch_a),
        .ch_b  (ch_b),
        .ch_c  (ch_c)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_reg  [16];
    int          m_cnt  [3];
    logic        m_tone [3];
    logic [3:0]  m_ch   [3];
    logic        m_pre;
    int          m_ncnt;
    logic [16:0] m_lfsr;

    function automatic logic [7:0] reg_mask(input logic [3:0] a);
        case (a)
            4'd0, 4'd2, 4'd4:                   return 8'hFF;
            4'd1, 4'd3, 4'd5, 4'd8, 4'd9, 4'd10: return 8'h0F;
            4'd6:                               return 8'h1F;
            4'd7:                               return 8'h3F;
            default:                            return 8'h00;
        endcase
    endfunction

    function automatic int tone_period(input int i);
        return int'({m_reg[2*i+1][3:0], m_reg[2*i]});
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_reg[i] <= 8'h00;
            for (int i = 0; i < 3; i++) begin
                m_cnt[i]  <= 0;
                m_tone[i] <= 1'b0;
                m_ch[i]   <= 4'h0;
            end
            m_pre  <= 1'b0;
            m_ncnt <= 0;
            m_lfsr <= 17'h00001;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (((m_tone[i] | m_reg[7][i]) & (m_lfsr[0] | m_reg[7][i+3])) == 1'b1)
                    m_ch[i] <= m_reg[8+i][3:0];
                else
                    m_ch[i] <= 4'h0;
            end
            if (ce) begin
                for (int i = 0; i < 3; i++) begin
                    if (m_cnt[i] + 1 >= tone_period(i)) begin
                        m_cnt[i]  <= 0;
                        m_tone[i] <= ~m_tone[i];
                    end else begin
                        m_cnt[i] <= m_cnt[i] + 1;
                    end
                end
                m_pre <= ~m_pre;
                if (m_pre) begin
                    if (m_ncnt + 1 >= int'(m_reg[6][4:0])) begin
                        m_ncnt <= 0;
                        m_lfsr <= {m_lfsr[0] ^ m_lfsr[3], m_lfsr[16:1]};
                    end else begin
                        m_ncnt <= m_ncnt + 1;
                    end
                end
            end
            if (bus.wr) m_reg[bus.addr] <= bus.din & reg_mask(bus.addr);
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ch_a_model", 32'(ch_a), 32'(m_ch[0]));
            check("ch_b_model", 32'(ch_b), 32'(m_ch[1]));
            check("ch_c_model", 32'(ch_c), 32'(m_ch[2]));
        end
    end

    // ---------------- stimulus helpers ----------------
    int phase = 0;

    task automatic cyc(input logic w, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        phase   = (phase + 1) % 32;
        ce      = (phase == 0);
        bus.wr   = w;
        bus.addr = a;
        bus.din  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 4'h0, 8'h00);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        cyc(1'b1, a, d);
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        cyc(1'b0, a, 8'h00);
        #1;
        check(name, 32'(bus.dout), 32'(exp));
    endtask

    function automatic logic [3:0] chv(input int sel);
        case (sel)
            0:       return ch_a;
            1:       return ch_b;
            default: return ch_c;
        endcase
    endfunction

    // Clocks until the selected channel changes; returns budget on timeout.
    task automatic wait_change(input int sel, input int budget, output int n);
        logic [3:0] prev;
        prev = chv(sel);
        n = 0;
        while (chv(sel) === prev && n < budget) begin
            idle(1);
            n++;
        end
    endtask

    task automatic set_reset(input logic v);
        @(posedge clk);
        #2 reset = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int total;
        int nce;
        reset    = 1'b1;
        ce       = 1'b0;
        bus.wr   = 1'b0;
        bus.addr = 4'h0;
        bus.din  = 8'h00;
        idle(3);
        cmp_en = 1'b1;
        check("reset_ch_a", 32'(ch_a), 32'h0);
        set_reset(1'b0);

        // Tone A period 4, only tone A enabled, full volume.
        wr_reg(AY_R_AFINE, 8'h04);
        wr_reg(AY_R_ACOARSE, 8'h00);
        wr_reg(AY_R_MIXER, 8'hFE);
        wr_reg(AY_R_VOLA, 8'h0F);
        wait_change(0, 300, n);
        wait_change(0, 300, n);
        wait_change(0, 300, n);
        check("period4_interval", 32'(n), 32'd128);
        wait_change(0, 300, n);
        check("period4_interval2", 32'(n), 32'd128);
        check("period4_ch_b", 32'(ch_b), 32'h0);
        check("period4_ch_c", 32'(ch_c), 32'h0);
        wr_reg(AY_R_VOLB, 8'h05);
        idle(2);
        check("both_off_dc", 32'(ch_b), 32'h5);
        idle(100);
        check("both_off_dc_hold", 32'(ch_b), 32'h5);

        // Period 0 and period 1 both toggle every ce.
        wr_reg(AY_R_AFINE, 8'h00);
        wait_change(0, 200, n);
        wait_change(0, 200, n);
        wait_change(0, 200, n);
        check("period0_interval", 32'(n), 32'd32);
        wr_reg(AY_R_AFINE, 8'h01);
        wait_change(0, 200, n);
        wait_change(0, 200, n);
        wait_change(0, 200, n);
        check("period1_interval", 32'(n), 32'd32);

        // Counter at 10 with period 16, then lower the period to 5.
        wr_reg(AY_R_AFINE, 8'h10);
        wait_change(0, 600, n);
        wait_change(0, 600, n);
        check("period16_interval", 32'(n), 32'd512);
        total = 0;
        nce   = 0;
        while (nce < 10) begin
            idle(1);
            total++;
            if (ce) nce++;
        end
        wr_reg(AY_R_AFINE, 8'h05);
        total++;
        wait_change(0, 600, n);
        total += n;
        check("lower_period_wrap", 32'(total), 32'd352);
        wait_change(0, 600, n);
        check("period5_interval", 32'(n), 32'd160);

        // Write coinciding with ce still compares against the old period.
        wr_reg(AY_R_AFINE, 8'h03);
        wait_change(0, 300, n);
        wait_change(0, 300, n);
        total = 0;
        while (phase != 31) begin
            idle(1);
            total++;
        end
        cyc(1'b1, AY_R_AFINE, 8'h01);
        total++;
        wait_change(0, 300, n);
        total += n;
        check("wr_with_ce_old_period", 32'(total), 32'd64);
        wait_change(0, 300, n);
        check("new_period_interval", 32'(n), 32'd32);

        // Readback masking.
        wr_reg(4'd12, 8'hAA);
        rd_check("rd_r12", 4'd12, 8'h00);
        wr_reg(AY_R_ACOARSE, 8'hFF);
        rd_check("rd_r1", AY_R_ACOARSE, 8'h0F);
        rd_check("rd_r7", AY_R_MIXER, 8'h3E);
        rd_check("rd_r8", AY_R_VOLA, 8'h0F);
        wr_reg(AY_R_NOISE, 8'hFF);
        rd_check("rd_r6", AY_R_NOISE, 8'h1F);

        // Reset mid-run with nonzero registers.
        set_reset(1'b1);
        #1;
        check("midreset_ch_a", 32'(ch_a), 32'h0);
        check("midreset_ch_b", 32'(ch_b), 32'h0);
        check("midreset_ch_c", 32'(ch_c), 32'h0);
        for (int a = 0; a < 16; a++) rd_check("midreset_reg", 4'(a), 8'h00);
        set_reset(1'b0);

        // Noise only on channel A; LFSR from seed 1 steps every 2 ce.
        wr_reg(AY_R_NOISE, 8'h01);
        wr_reg(AY_R_MIXER, 8'hF7);
        wr_reg(AY_R_VOLA, 8'h08);
        idle(2);
        check("noise_seed_bit", 32'(ch_a), 32'h8);
        wait_change(0, 200, n);
        check("noise_first_step", 32'(ch_a), 32'h0);
        wait_change(0, 1200, n);
        check("noise_low_16", 32'(n), 32'd1024);
        wait_change(0, 200, n);
        check("noise_high_1", 32'(n), 32'd64);
        wait_change(0, 1000, n);
        check("noise_low_13", 32'(n), 32'd832);
        check("noise_ch_b", 32'(ch_b), 32'h0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
